// File: rtl/instr_queue.sv
// -----------------------------------------------------------------------------
// instr_queue
//   In-order instruction queue between fetch and decode. Buffers up to DEPTH
//   {instruction, PC} pairs in a circular buffer. Fetch and decode each use a
//   valid/ready handshake. A flush drops every buffered entry so that
//   wrong-path instructions never reach decode.
//
// Optional feature macro: INSTR_QUEUE_BYPASS_EN
//   When defined and the queue is empty, the incoming pair is presented to
//   decode combinationally (0-cycle latency). If decode accepts the pair in
//   that same cycle, it is not written into the buffer.
//
// Parameters
//   T      word type for instruction and PC (default logic [31:0])
//   DEPTH  entry count; must be a power of two and at least 2
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous reset, active low
//   flush      synchronous discard of all entries
//   in_instr   instruction from fetch
//   in_pc      PC of in_instr
//   in_valid   fetch presents a pair
//   in_ready   queue can accept a pair (depends on registered state only)
//   out_instr  oldest instruction
//   out_pc     PC of out_instr
//   out_valid  out_instr/out_pc are valid
//   out_ready  decode consumes the presented pair
//   count      current occupancy
// -----------------------------------------------------------------------------
module instr_queue #(
   parameter type         T     = logic [31:0],
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  T                           in_instr,
   input  T                           in_pc,
   input  logic                       in_valid,
   output logic                       in_ready,
   output T                           out_instr,
   output T                           out_pc,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   T              r_instr_mem [DEPTH];
   T              r_pc_mem    [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic w_empty;
   logic w_full;
   logic w_push;
   logic w_pop;

   assign w_empty  = (r_count == '0);
   assign w_full   = (r_count == CW'(DEPTH));
   assign in_ready = !w_full;
   assign count    = r_count;

`ifdef INSTR_QUEUE_BYPASS_EN
   logic w_bypass;

   // An empty queue forwards the incoming pair straight to decode.
   assign w_bypass  = w_empty && in_valid && !flush;
   assign out_valid = !w_empty || w_bypass;
   assign out_instr = w_bypass ? in_instr : r_instr_mem[r_rd_ptr];
   assign out_pc    = w_bypass ? in_pc    : r_pc_mem[r_rd_ptr];
   // A bypassed pair taken by decode in the same cycle is never stored.
   assign w_push    = in_valid && in_ready && !flush && !(w_bypass && out_ready);
   assign w_pop     = !w_empty && out_ready && !flush;
`else
   assign out_valid = !w_empty;
   assign out_instr = r_instr_mem[r_rd_ptr];
   assign out_pc    = r_pc_mem[r_rd_ptr];
   assign w_push    = in_valid && in_ready && !flush;
   assign w_pop     = out_valid && out_ready && !flush;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_instr_mem[i] <= '0;
            r_pc_mem[i]    <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_instr_mem[r_wr_ptr] <= in_instr;
            r_pc_mem[r_wr_ptr]    <= in_pc;
            r_wr_ptr              <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_queue
//   Directed stimulus for instr_queue. The driver pushes each accepted pair
//   into a scoreboard; an independent monitor pops and compares every pair
//   that decode consumes. Occupancy/handshake flags are checked directly
//   against hand-computed values.
// -----------------------------------------------------------------------------
module tb_instr_queue;

   typedef logic [31:0] word_t;

   logic  clk = 1'b0;
   logic  reset;
   logic  flush;
   word_t in_instr;
   word_t in_pc;
   logic  in_valid;
   logic  in_ready;
   word_t out_instr;
   word_t out_pc;
   logic  out_valid;
   logic  out_ready;
   logic [2:0] count;

   int errors = 0;
   int checks = 0;
   int pops   = 0;

   word_t sb_pc[$];
   word_t sb_instr[$];

   instr_queue #(.T(word_t), .DEPTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_instr  (in_instr),
      .in_pc     (in_pc),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_instr (out_instr),
      .out_pc    (out_pc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .count     (count)
   );

   // Rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   function automatic word_t instr_of(input word_t pc);
      return ~pc ^ 32'h0BAD_0000;
   endfunction

   task automatic chk(input string name, input word_t act, input word_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One cycle of stimulus: drive 1 ns after the edge, record acceptance
   // 4 ns after the edge (the monitor samples at the falling edge, 5 ns after).
   task automatic step(input logic v, input word_t pc, input logic rdy, input logic fl);
      @(posedge clk);
      #1;
      in_valid  = v;
      in_pc     = pc;
      in_instr  = instr_of(pc);
      out_ready = rdy;
      flush     = fl;
      #3;
      if (fl) begin
         sb_pc.delete();
         sb_instr.delete();
      end else if (v && in_ready) begin
         sb_pc.push_back(pc);
         sb_instr.push_back(instr_of(pc));
      end
   endtask

   // Monitor: every pair consumed by decode must be the oldest expected one.
   always @(negedge clk) begin
      if (reset && out_valid && out_ready && !flush) begin
         pops++;
         checks++;
         if (sb_pc.size() == 0) begin
            errors++;
            $display("FAIL mon_unexpected: got pc %h expected no output", out_pc);
         end else begin
            word_t epc;
            word_t ein;
            epc = sb_pc.pop_front();
            ein = sb_instr.pop_front();
            if (out_pc !== epc || out_instr !== ein) begin
               errors++;
               $display("FAIL mon_data: got pc %h instr %h expected pc %h instr %h",
                        out_pc, out_instr, epc, ein);
            end
         end
      end
   end

   initial begin
      #100000;
      errors++;
      $display("FAIL timeout: got no completion expected finish before 100000 ns");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      int p0;
      reset     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_pc     = '0;
      in_instr  = '0;
      out_ready = 1'b0;

      // Reset held two cycles, then idle.
      repeat (2) begin
         @(posedge clk);
         #4;
         chk("rst_out_valid", 32'(out_valid), 32'd0);
         chk("rst_in_ready",  32'(in_ready),  32'd1);
         chk("rst_count",     32'(count),     32'd0);
         chk("rst_out_pc",    out_pc,         32'd0);
         chk("rst_out_instr", out_instr,      32'd0);
      end
      #1 reset = 1'b1;
      repeat (3) begin
         step(1'b0, 32'h0, 1'b0, 1'b0);
         chk("idle_out_valid", 32'(out_valid), 32'd0);
         chk("idle_in_ready",  32'(in_ready),  32'd1);
         chk("idle_count",     32'(count),     32'd0);
         chk("idle_out_pc",    out_pc,         32'd0);
      end

      // Fill to DEPTH with decode stalled.
      for (int i = 0; i < 4; i++) step(1'b1, word_t'(4 * i), 1'b0, 1'b0);
      step(1'b1, 32'h10, 1'b0, 1'b0);
      chk("full_count",    32'(count),    32'd4);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      // Full while popping: still not accepting.
      p0 = pops;
      step(1'b1, 32'h10, 1'b1, 1'b0);
      chk("full_pop_in_ready", 32'(in_ready), 32'd0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("after_pop_in_ready", 32'(in_ready), 32'd1);
      chk("after_pop_count",    32'(count),    32'd3);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("drain_pops",      32'(pops - p0), 32'd4);
      chk("drain_out_valid", 32'(out_valid), 32'd0);
      chk("drain_count",     32'(count),     32'd0);

      // Sustained push+pop at count=2 across several pointer wraps.
      step(1'b1, 32'h100, 1'b0, 1'b0);
      step(1'b1, 32'h104, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         step(1'b1, word_t'(32'h108 + 4 * k), 1'b1, 1'b0);
         chk("stream_count",     32'(count),     32'd2);
         chk("stream_out_valid", 32'(out_valid), 32'd1);
      end
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("stream_empty", 32'(out_valid), 32'd0);

      // Flush at count=3 with push and pop in the same cycle.
      step(1'b1, 32'h200, 1'b0, 1'b0);
      step(1'b1, 32'h204, 1'b0, 1'b0);
      step(1'b1, 32'h208, 1'b0, 1'b0);
      step(1'b1, 32'h20C, 1'b1, 1'b1);
      chk("preflush_count", 32'(count), 32'd3);
      step(1'b1, 32'h2000, 1'b0, 1'b0);
      chk("flush_count",     32'(count),     32'd0);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_in_ready",  32'(in_ready),  32'd1);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("postflush_out_pc", out_pc, 32'h2000);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("postflush_empty", 32'(out_valid), 32'd0);

      // Asynchronous reset mid-cycle at count=3.
      step(1'b1, 32'h300, 1'b0, 1'b0);
      step(1'b1, 32'h304, 1'b0, 1'b0);
      step(1'b1, 32'h308, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("prereset_count", 32'(count), 32'd3);
      #2 reset = 1'b0;
      #1;
      chk("arst_count",     32'(count),     32'd0);
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_in_ready",  32'(in_ready),  32'd1);
      chk("arst_out_pc",    out_pc,         32'd0);
      sb_pc.delete();
      sb_instr.delete();
      @(posedge clk);
      #1 reset = 1'b1;

      // Empty-queue latency, with or without bypass.
      step(1'b1, 32'h40, 1'b1, 1'b0);
`ifdef INSTR_QUEUE_BYPASS_EN
      chk("byp_out_valid", 32'(out_valid), 32'd1);
      chk("byp_out_pc",    out_pc,         32'h40);
      chk("byp_count",     32'(count),     32'd0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("byp_after_count", 32'(count),     32'd0);
      chk("byp_after_valid", 32'(out_valid), 32'd0);
`else
      chk("lat_same_valid", 32'(out_valid), 32'd0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("lat_next_valid", 32'(out_valid), 32'd1);
      chk("lat_next_pc",    out_pc,         32'h40);
      chk("lat_next_count", 32'(count),     32'd1);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("lat_after_valid", 32'(out_valid), 32'd0);
`endif

      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("sb_leftover", 32'(sb_pc.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_queue.md
# instr_queue

Instruction queue on the consuming side of the fetch-to-decode valid/ready handshake. Accepts one {instruction, PC} pair per cycle from fetch, buffers up to DEPTH entries in order, and presents the oldest entry to decode under its own valid/ready handshake. A flush input discards all buffered entries on branch redirection, so wrong-path instructions never reach decode.

## Interface
- T, logic [31:0], type of instruction and PC words
- DEPTH, 4, number of entries; power of two, >= 2
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- flush  input  1  discard all entries (branch taken); synchronous
- in_instr  input  $bits(T)  instruction from fetch
- in_pc  input  $bits(T)  PC of in_instr
- in_valid  input  1  fetch presents a valid pair
- in_ready  output  1  queue can accept this cycle
- out_instr  output  $bits(T)  oldest instruction to decode
- out_pc  output  $bits(T)  PC of out_instr
- out_valid  output  1  out_instr/out_pc valid
- out_ready  input  1  decode consumes this cycle
- count  output  $clog2(DEPTH+1)  current occupancy

## Operation
- Storage: DEPTH-entry circular buffer of {instr, pc}; read and write pointers of $clog2(DEPTH) bits wrap naturally from DEPTH-1 to 0.
- push = in_valid && in_ready && !flush; writes entry at write pointer, advances it.
- pop = out_valid && out_ready && !flush; advances read pointer.
- count next = count + push - pop; push and pop in the same cycle leave count unchanged.
- in_ready = (count != DEPTH); depends only on registered state, never on out_ready. A full queue does not accept even when popping that cycle.
- out_valid = (count != 0); out_instr/out_pc = entry at read pointer, driven combinationally from storage.
- flush: pointers and count to 0 next cycle; any push or pop that cycle is ignored. Entry contents need not be cleared.
- flush takes priority over push and pop; no other priority rules exist.
- Reset (asynchronous, any time, including mid-operation): pointers, count, and all entries to 0. Outputs during and after reset: out_valid=0, in_ready=1, count=0, out_instr=0, out_pc=0.
- Order is strictly FIFO; no entry is dropped or duplicated except by flush or reset.

## Timing
- Without bypass: a push into an empty queue shows out_valid=1 on the cycle after the push edge. Minimum latency is 1 cycle.
- Throughput: 1 entry/cycle sustained when 0 < count < DEPTH and both sides are ready.
- in_ready falls the cycle after the push that fills the queue. It rises the cycle after the first pop from full.
- After flush: out_valid=0 and in_ready=1 on the following cycle. A push on that following cycle is accepted normally.
- Fetch holds in_valid/in_instr/in_pc stable while in_valid && !in_ready. The queue does not depend on this beyond sampling on push.

## Configuration
- INSTR_QUEUE_BYPASS_EN defined:
  - When count==0 and in_valid && !flush, out_valid=1 combinationally, with out_instr=in_instr and out_pc=in_pc.
  - If out_ready is also 1, the pair goes directly to decode and is not written (count stays 0).
  - If out_ready=0, the pair is written as a normal push.
  - Gives 0-cycle latency when the queue is empty.
- Not defined: no combinational in-to-out path; behaviour exactly as in Operation and Timing.

## Test plan
- Reset then idle: hold reset=0 for 2 cycles, then release -> out_valid=0, in_ready=1, count=0, out_pc=0 on every cycle.
- Fill and drain: out_ready=0, push PCs 0x0,0x4,0x8,0xC -> count=4 and in_ready=0; a 5th in_valid is not accepted. Set out_ready=1 -> out_pc 0x0,0x4,0x8,0xC on 4 consecutive cycles, then out_valid=0.
- Simultaneous push/pop at count=2 for 10 cycles with PCs 0x100 onward -> count stays 2; outputs in order with no gap; pointers wrap past DEPTH-1 correctly.
- Flush with push and pop in the same cycle at count=3 -> next cycle count=0, out_valid=0. A subsequent push of PC 0x2000 appears as the first output.
- Asynchronous reset asserted mid-cycle at count=3 -> count=0 and out_valid=0 immediately, without waiting for a clock edge.
- INSTR_QUEUE_BYPASS_EN defined: empty queue, in_valid=1 with PC 0x40, out_ready=1 -> out_pc=0x40 and out_valid=1 in the same cycle, count remains 0. Without the macro -> out_valid=1 the next cycle.
